// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - word request/ack bus shared by the arbiter's ports and its RAM FSM side
interface ram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;    // on the RAM side this carries the FSM's done pulse
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port cellular-RAM arbiter with access watchdog
// RAM_ARB_RR_EN: round-robin tie-break (default build: fixed priority to port 0).
module ram_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    ram_arbiter_if.slave     p0,
    ram_arbiter_if.slave     p1,
    ram_arbiter_if.master    mem,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        timer;
    logic              grant;
    logic              any_req;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req = p0.req | p1.req;

`ifdef RAM_ARB_RR_EN
    logic last_grant;
    assign pick = (p0.req && p1.req) ? ~last_grant : p1.req;
`else
    assign pick = ~p0.req;
`endif

    assign sel_we    = pick ? p1.we    : p0.we;
    assign sel_addr  = pick ? p1.addr  : p0.addr;
    assign sel_wdata = pick ? p1.wdata : p0.wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= 8'd0;
            grant     <= 1'b0;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= {ADDR_W{1'b0}};
            mem.wdata <= {DATA_W{1'b0}};
            p0.ack    <= 1'b0;
            p1.ack    <= 1'b0;
            p0.rdata  <= {DATA_W{1'b0}};
            p1.rdata  <= {DATA_W{1'b0}};
            err       <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            p0.ack <= 1'b0;
            p1.ack <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= pick;
                        mem.req   <= 1'b1;
                        mem.we    <= sel_we;
                        mem.addr  <= sel_addr;
                        mem.wdata <= sel_wdata;
                        timer     <= 8'd0;
`ifdef RAM_ARB_RR_EN
                        last_grant <= pick;
`endif
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // done takes precedence over a timeout landing in the same cycle
                    if (mem.ack) begin
                        if (!mem.we) begin
                            if (grant) p1.rdata <= mem.rdata;
                            else       p0.rdata <= mem.rdata;
                        end
                        mem.req <= 1'b0;
                        if (grant) p1.ack <= 1'b1;
                        else       p0.ack <= 1'b1;
                        state   <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        if (!mem.we) begin
                            if (grant) p1.rdata <= {DATA_W{1'b0}};
                            else       p0.rdata <= {DATA_W{1'b0}};
                        end
                        mem.req <= 1'b0;
                        if (grant) p1.ack <= 1'b1;
                        else       p0.ack <= 1'b1;
                        err     <= 1'b1;
                        state   <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized bench for ram_arbiter against a transaction-level model
module tb_ram_arbiter;
    localparam int TIMEOUT = 15;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    ram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) p0_if ();
    ram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) p1_if ();
    ram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) mem_if ();

    ram_arbiter #(.ADDR_W(20), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .p0  (p0_if),
        .p1  (p1_if),
        .mem (mem_if),
        .err (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rq[2];
    logic        rwe[2];
    logic [19:0] raddr[2];
    logic [15:0] rwdata[2];
    logic [15:0] exp_rdata[2];
    int          m_last;
    bit          from_resp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        p0_if.req = rq[0]; p0_if.we = rwe[0]; p0_if.addr = raddr[0]; p0_if.wdata = rwdata[0];
        p1_if.req = rq[1]; p1_if.we = rwe[1]; p1_if.addr = raddr[1]; p1_if.wdata = rwdata[1];
    endtask

    task automatic set_req(input int p, input logic we, input logic [19:0] a, input logic [15:0] d);
        rq[p] = 1'b1; rwe[p] = we; raddr[p] = a; rwdata[p] = d;
    endtask

    // One access: predicts the winner and outcome, plays the RAM FSM with the given latency
    // (lat outside 1..TIMEOUT means done never arrives), then checks the response.
    task automatic run_access(input int lat, input logic [15:0] d, output int obs);
        int exp_win, exp_lat, exp_hi, n, hi;
        logic timed_out, stable, early_ack;
        apply();
        if (rq[0] && rq[1]) exp_win = (RR && m_last == 0) ? 1 : 0;
        else                exp_win = rq[1] ? 1 : 0;
        m_last    = exp_win;
        timed_out = (lat < 1 || lat > TIMEOUT);
        exp_hi    = timed_out ? TIMEOUT : lat;
        exp_lat   = from_resp ? 2 : 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_if.req && n < 8);
        check("req_latency", 32'(n), 32'(exp_lat));
        check("mem_we", 32'(mem_if.we), 32'(rwe[exp_win]));
        check("mem_addr", 32'(mem_if.addr), 32'(raddr[exp_win]));
        check("mem_wdata", 32'(mem_if.wdata), 32'(rwdata[exp_win]));
        stable = 1'b1; early_ack = 1'b0; hi = 0;
        while (mem_if.req && hi < 400) begin
            hi++;
            if (mem_if.we !== rwe[exp_win] || mem_if.addr !== raddr[exp_win] ||
                mem_if.wdata !== rwdata[exp_win]) stable = 1'b0;
            if (p0_if.ack || p1_if.ack || err) early_ack = 1'b1;
            if (hi == lat) begin mem_if.ack = 1'b1; mem_if.rdata = d; end
            @(negedge clk);
            mem_if.ack = 1'b0; mem_if.rdata = 16'($urandom);
        end
        check("req_cycles", 32'(hi), 32'(exp_hi));
        check("mem_stable", 32'(stable), 32'd1);
        check("ack_in_wait", 32'(early_ack), 32'd0);
        check("ack_onehot", 32'({p1_if.ack, p0_if.ack}), exp_win ? 32'd2 : 32'd1);
        check("err", 32'(err), 32'(timed_out));
        if (!rwe[exp_win]) exp_rdata[exp_win] = timed_out ? 16'h0000 : d;
        check("p0_rdata", 32'(p0_if.rdata), 32'(exp_rdata[0]));
        check("p1_rdata", 32'(p1_if.rdata), 32'(exp_rdata[1]));
        obs = p1_if.ack ? 1 : (p0_if.ack ? 0 : -1);
        rq[exp_win] = 1'b0;
        apply();
        from_resp = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int obs, n, lat;
        int exp_g[5];
        logic seen;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rwdata[p] = '0; exp_rdata[p] = '0;
        end
        m_last = 1; from_resp = 1'b0;
        apply();
        mem_if.ack = 1'b0; mem_if.rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_if.req), 32'd0);
        check("rst_mem_we", 32'(mem_if.we), 32'd0);
        check("rst_mem_addr", 32'(mem_if.addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_if.wdata), 32'd0);
        check("rst_acks", 32'({p1_if.ack, p0_if.ack, err}), 32'd0);
        check("rst_rdata", 32'({p1_if.rdata, p0_if.rdata}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_req(0, 1'b0, 20'h00010, 16'h0000);
        run_access(3, 16'hBEEF, obs);
        check("single_read_rdata", 32'(p0_if.rdata), 32'hBEEF);

        set_req(1, 1'b0, 20'h00200, 16'h0000);
        run_access(2, 16'h7777, obs);
        set_req(1, 1'b1, 20'h5DC00, 16'hA5A5);
        run_access(2, 16'h3C3C, obs);
        check("write_keeps_rdata", 32'(p1_if.rdata), 32'h7777);
        set_req(1, 1'b0, 20'h00300, 16'h0000);
        run_access(0, 16'hFFFF, obs);
        check("timeout_rdata", 32'(p1_if.rdata), 32'h0000);
        set_req(0, 1'b0, 20'h00400, 16'h0000);
        run_access(TIMEOUT, 16'h1234, obs);

        exp_g = RR ? '{0, 1, 0, 1, 1} : '{0, 0, 0, 0, 1};
        set_req(0, 1'b0, 20'h01000, 16'h0000);
        set_req(1, 1'b1, 20'h02000, 16'h5A5A);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) rq[0] = 1'b0;
            run_access(2, 16'($urandom), obs);
            check("grant_seq", 32'(obs), 32'(exp_g[i]));
            if (i < 3) rq[obs] = 1'b1;
            if (i == 3) rq[1] = 1'b1;
        end
        rq[0] = 1'b0; rq[1] = 1'b0; apply();

        set_req(1, 1'b0, 20'h0ABCD, 16'h0000);
        apply();
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_if.req && n < 8);
        check("rst_test_req_seen", 32'(mem_if.req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_mem_req", 32'(mem_if.req), 32'd0);
        check("async_rst_acks", 32'({p1_if.ack, p0_if.ack, err}), 32'd0);
        exp_rdata[0] = '0; exp_rdata[1] = '0; m_last = 1;
        rq[1] = 1'b0; apply();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_if.ack = (i == 2);
            @(negedge clk);
            if (p0_if.ack || p1_if.ack || err || mem_if.req) seen = 1'b1;
        end
        mem_if.ack = 1'b0;
        check("quiet_after_rst", 32'(seen), 32'd0);
        from_resp = 1'b0;
        set_req(0, 1'b0, 20'h00042, 16'h0000);
        run_access(1, 16'h4242, obs);

        for (int it = 0; it < 50; it++) begin
            for (int p = 0; p < 2; p++)
                if (!rq[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom), 20'($urandom), 16'($urandom));
            if (!rq[0] && !rq[1]) begin
                n = int'($urandom_range(0, 1));
                set_req(n, 1'($urandom), 20'($urandom), 16'($urandom));
            end
            lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                              : int'($urandom_range(1, 4));
            run_access(lat, 16'($urandom), obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the external cellular-RAM access path between the audio playback reader (port 0) and the sample recorder/writer (port 1). It accepts word requests from both, selects one, and drives a single held request into the async RAM access FSM. It waits for that FSM's completion pulse, then returns a one-cycle acknowledge and the read data to the winning port. A watchdog aborts any access that never completes, so a stuck RAM cycle cannot stall audio.

## Interface
- ADDR_W, 20, word address width (matches 20-bit RAM word address)
- DATA_W, 16, data bus width
- TIMEOUT, 15, max WAIT cycles before abort; legal range 1..255
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- p0_req / p1_req  in  1  request; held high until matching ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr / p1_addr  in  ADDR_W  word address; stable while req high
- p0_wdata / p1_wdata  in  DATA_W  write data; stable while req high
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  DATA_W  read data, valid in ack cycle, held until next ack to that port
- mem_req  out  1  access request to RAM FSM; level, held until done/timeout
- mem_we  out  1  write select for current access
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_done  in  1  one-cycle completion pulse from RAM FSM
- mem_rdata  in  DATA_W  read data, valid when mem_done high
- err  out  1  one-cycle pulse in ack cycle of a timed-out access

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: if any req high, pick winner per Configuration, register we/addr/wdata into mem_*, store grant index, clear timer, go WAIT. No req: stay IDLE.
- WAIT: mem_req=1. mem_done high: capture mem_rdata (read) into winner's rdata, go RESP. Else timer increments; timer reaching TIMEOUT-1 with no done: winner's rdata := 0 (read only), set abort flag, go RESP.
- mem_done and timeout in the same cycle: done wins, no err.
- RESP: mem_req=0; winner's ack=1; err=abort flag; go IDLE. Loser's req is untouched and is considered in the following IDLE.
- Write accesses never modify pN_rdata.
- mem_done outside WAIT is ignored.
- Granted port dropping req mid-access: access still completes, ack still pulses (protocol violation; no special handling).
- Timer width 8 bits; no wrap possible within legal TIMEOUT.

## Timing
- Reset (async assert): state IDLE, mem_req/mem_we/ack/err = 0, mem_addr/mem_wdata/pN_rdata = 0, timer 0, last-grant = port 1. Outputs drop immediately; an in-flight access is abandoned without ack.
- Req sampled high in IDLE cycle N: mem_req/mem_* valid from cycle N+1.
- mem_done in cycle K: ack (and rdata) in cycle K+1, IDLE in K+2. Minimum req-to-ack = 2 cycles; back-to-back same-port throughput one access per 3 cycles plus RAM latency.
- Timeout: with no done, mem_req high for exactly TIMEOUT cycles; ack+err in the next cycle.
- Requester may deassert req in the ack cycle; if still high in the following IDLE cycle, it is a new request.

## Configuration
- RAM_ARB_RR_EN defined: round-robin; on simultaneous requests, the port not granted last wins; last-grant updates on every grant.
- Not defined: fixed priority; port 0 always wins ties; last-grant register absent.

## Test plan
- Single read: p0 read addr 0x00010, mem_done in 3rd WAIT cycle with rdata 0xBEEF -> mem_req high 3 cycles, p0_ack one cycle later with p0_rdata=0xBEEF, err=0.
- Simultaneous p0 read/p1 write held for 4 accesses -> RR_EN: grants 0,1,0,1; without: p0 granted all 4, p1 only after p0 drops.
- Timeout: TIMEOUT=15, no mem_done -> mem_req high exactly 15 cycles, then p1_ack=1, err=1, p1_rdata=0x0000 for a read.
- Done on last timeout cycle (cycle 15) with rdata 0x1234 -> ack with rdata 0x1234, err=0.
- Async reset asserted mid-WAIT -> mem_req and all acks 0 immediately, no ack after release, next request served normally from IDLE.
- Write from p1 (addr 0x5DC00, data 0xA5A5) -> mem_we=1, mem_wdata=0xA5A5 while mem_req high, p1_rdata unchanged after ack.
